uart_tx_msg_sequencer: RTL and testbench

Controller that sequences a multi-character message into the uart_transmitter. It latches a packed message on a start pulse and issues one Tx_WR per character, honouring the transmitter's Tx_BUSY handshake. It inserts a programmable idle gap between characters and supports one-shot or repeating transmission. It is the transmit-side counterpart of the display listener path and feeds the TxD line that the receiver/LED driver chain consumes.

---
 rtl/uart_tx_msg_sequencer.sv | 157 +++++++++++++++
 tb/tb_uart_tx_msg_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_msg_sequencer.sv
// rtl/uart_tx_msg_sequencer.sv - sequences a latched multi-character message into a UART transmitter
module uart_tx_msg_sequencer #(
    parameter int NUM_CHARS   = 4,
    parameter int GAP_CYCLES  = 16,
    parameter int ACK_TIMEOUT = 8,
    localparam int IDX_W      = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   repeat_en,
    input  logic [8*NUM_CHARS-1:0] msg_data,
    input  logic                   Tx_BUSY,
    output logic                   Tx_WR,
    output logic [7:0]             Tx_DATA,
    output logic                   busy,
    output logic [IDX_W-1:0]       char_idx,
    output logic                   done,
    output logic                   tx_error
);

    localparam int CNT_MAX = (GAP_CYCLES > ACK_TIMEOUT) ? GAP_CYCLES : ACK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

    localparam logic [CNT_W-1:0] ACK_LIM  = CNT_W'(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_t;

    // With no gap configured the next character is loaded straight away.
    localparam state_t AFTER_CHAR = (GAP_CYCLES == 0) ? LOAD : GAP;

    state_t                 state_q, state_d;
    logic [8*NUM_CHARS-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0]       char_idx_q, char_idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   tx_wr_q, tx_wr_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   done_q, done_d;
    logic                   tx_error_q, tx_error_d;
    logic [CNT_W-1:0]       cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        char_idx_d = char_idx_q;
        cnt_d      = cnt_q;
        tx_wr_d    = 1'b0;
        tx_data_d  = tx_data_q;
        done_d     = 1'b0;
        tx_error_d = 1'b0;

        if (abort) begin
            state_d    = IDLE;
            char_idx_d = '0;
            cnt_d      = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shadow_d   = msg_data;
                        char_idx_d = '0;
                        cnt_d      = '0;
                        state_d    = LOAD;
                    end
                end
                LOAD: begin
                    if (!Tx_BUSY) begin
                        tx_wr_d   = 1'b1;
                        tx_data_d = shadow_q[char_idx_q*8 +: 8];
                        cnt_d     = '0;
                        state_d   = WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (Tx_BUSY) begin
                        state_d = WAIT_DONE;
                    end else if (cnt_inc == ACK_LIM) begin
                        tx_error_d = 1'b1;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                WAIT_DONE: begin
                    if (!Tx_BUSY) begin
                        cnt_d = '0;
                        if (char_idx_q != LAST_IDX) begin
                            char_idx_d = char_idx_q + 1'b1;
                            state_d    = AFTER_CHAR;
                        end else if (repeat_en) begin
                            // Re-latching here is the only point where new message data is taken.
                            shadow_d   = msg_data;
                            char_idx_d = '0;
                            state_d    = AFTER_CHAR;
                        end else begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d   = '0;
                        state_d = LOAD;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            char_idx_q <= '0;
            cnt_q      <= '0;
            tx_wr_q    <= 1'b0;
            tx_data_q  <= 8'h00;
            done_q     <= 1'b0;
            tx_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            char_idx_q <= char_idx_d;
            cnt_q      <= cnt_d;
            tx_wr_q    <= tx_wr_d;
            tx_data_q  <= tx_data_d;
            done_q     <= done_d;
            tx_error_q <= tx_error_d;
        end
    end

    assign Tx_WR    = tx_wr_q;
    assign Tx_DATA  = tx_data_q;
    assign busy     = (state_q != IDLE);
    assign char_idx = char_idx_q;
    assign done     = done_q;
    assign tx_error = tx_error_q;

endmodule

// File: tb/tb_uart_tx_msg_sequencer.sv
// tb/tb_uart_tx_msg_sequencer.sv - self-checking bench for uart_tx_msg_sequencer
module tb_uart_tx_msg_sequencer;

    localparam int NC       = 4;
    localparam int GAP      = 16;
    localparam int ACKT     = 8;
    localparam int BUSY_LEN = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        repeat_en = 1'b0;
    logic [31:0] msg_data = 32'h0;
    logic        Tx_BUSY;
    logic        Tx_WR;
    logic [7:0]  Tx_DATA;
    logic        busy;
    logic [1:0]  char_idx;
    logic        done;
    logic        tx_error;

    always #5 clk = ~clk;

    uart_tx_msg_sequencer #(
        .NUM_CHARS  (NC),
        .GAP_CYCLES (GAP),
        .ACK_TIMEOUT(ACKT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .repeat_en(repeat_en),
        .msg_data (msg_data),
        .Tx_BUSY  (Tx_BUSY),
        .Tx_WR    (Tx_WR),
        .Tx_DATA  (Tx_DATA),
        .busy     (busy),
        .char_idx (char_idx),
        .done     (done),
        .tx_error (tx_error)
    );

    // Transmitter model: busy for BUSY_LEN cycles after each accepted write.
    int   busy_cnt = 0;
    logic ack_en = 1'b1;
    logic force_busy = 1'b0;

    always @(posedge clk) begin
        if (Tx_WR && ack_en) busy_cnt <= BUSY_LEN;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign Tx_BUSY = force_busy | (busy_cnt != 0);

    int         cyc = 0;
    logic       busy_prev = 1'b0;
    int         last_fall = 0;
    logic [7:0] wr_q[$];
    int         wr_cyc[$];
    int         gap_q[$];
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         err_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (busy_prev && !Tx_BUSY) last_fall = cyc;
        busy_prev = Tx_BUSY;
        if (Tx_WR) begin
            wr_q.push_back(Tx_DATA);
            wr_cyc.push_back(cyc);
            gap_q.push_back(cyc - last_fall);
        end
        if (done) done_cnt++;
        if (tx_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wr_q.delete();
        wr_cyc.delete();
        gap_q.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check("idle_within_budget", busy, 1'b0);
    endtask

    task automatic wait_tx_busy(input logic lvl, input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (Tx_BUSY === lvl) break;
            @(negedge clk);
        end
        check("tx_busy_level_reached", Tx_BUSY, lvl);
    endtask

    task automatic run_repeat(input logic [31:0] new_msg, input int change_at, input logic [63:0] exp_seq);
        logic changed;
        clear_log();
        msg_data  = 32'h44434241;
        repeat_en = 1'b1;
        changed   = 1'b0;
        pulse_start();
        for (int i = 0; i < 1000; i++) begin
            if (!changed && wr_q.size() >= change_at) begin
                msg_data = new_msg;
                changed  = 1'b1;
            end
            if (wr_q.size() >= 7) repeat_en = 1'b0;
            if (!busy) break;
            @(negedge clk);
        end
        check("rpt_idle", busy, 1'b0);
        @(negedge clk);
        check("rpt_wr_count", wr_q.size(), 8);
        for (int k = 0; k < 8; k++)
            if (k < wr_q.size())
                check($sformatf("rpt_char%0d", k), wr_q[k], exp_seq[63-8*k -: 8]);
        check("rpt_done_count", done_cnt, 1);
        check("rpt_err_count", err_cnt, 0);
    endtask

    // Expected characters are written in transmit order, first char in the top byte.
    typedef struct {
        logic [31:0] msg;
        logic [31:0] exp_seq;
    } vec_t;

    vec_t vecs [3];
    int   lat;

    initial begin
        vecs[0] = '{msg: 32'h44434241, exp_seq: 32'h41424344};
        vecs[1] = '{msg: 32'h00FF5AA5, exp_seq: 32'hA55AFF00};
        vecs[2] = '{msg: 32'h01020304, exp_seq: 32'h04030201};

        repeat (2) @(negedge clk);
        check("rst_tx_wr", Tx_WR, 1'b0);
        check("rst_tx_data", Tx_DATA, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_char_idx", char_idx, 2'd0);
        check("rst_done", done, 1'b0);
        check("rst_tx_error", tx_error, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // One-shot messages; msg_data is scrambled after start to prove it was latched.
        for (int v = 0; v < 3; v++) begin
            clear_log();
            msg_data  = vecs[v].msg;
            repeat_en = 1'b0;
            pulse_start();
            msg_data = 32'h55555555;
            check($sformatf("v%0d_load_busy", v), busy, 1'b1);
            check($sformatf("v%0d_load_no_wr", v), Tx_WR, 1'b0);
            @(negedge clk);
            check($sformatf("v%0d_first_wr", v), Tx_WR, 1'b1);
            check($sformatf("v%0d_first_data", v), Tx_DATA, vecs[v].exp_seq[31:24]);
            wait_idle(400);
            @(negedge clk);
            check($sformatf("v%0d_wr_count", v), wr_q.size(), 4);
            for (int k = 0; k < 4; k++)
                if (k < wr_q.size())
                    check($sformatf("v%0d_char%0d", v, k), wr_q[k], vecs[v].exp_seq[31-8*k -: 8]);
            // Busy fall cycle, GAP cycles, one LOAD cycle, then Tx_WR.
            for (int k = 1; k < 4; k++)
                if (k < gap_q.size())
                    check($sformatf("v%0d_gap%0d", v, k), gap_q[k], GAP + 2);
            check($sformatf("v%0d_done_count", v), done_cnt, 1);
            check($sformatf("v%0d_err_count", v), err_cnt, 0);
            check($sformatf("v%0d_data_held", v), Tx_DATA, vecs[v].exp_seq[7:0]);
        end

        // Transmitter busy at start: sequencer parks in LOAD.
        clear_log();
        msg_data   = 32'h44434241;
        force_busy = 1'b1;
        pulse_start();
        repeat (10) @(negedge clk);
        check("fb_busy", busy, 1'b1);
        check("fb_no_wr", wr_q.size(), 0);
        check("fb_tx_wr_low", Tx_WR, 1'b0);
        force_busy = 1'b0;
        @(negedge clk);
        check("fb_wr_after_release", Tx_WR, 1'b1);
        check("fb_data", Tx_DATA, 8'h41);
        wait_idle(400);
        @(negedge clk);
        check("fb_done_count", done_cnt, 1);

        // Transmitter never acknowledges.
        clear_log();
        ack_en = 1'b0;
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            if (tx_error) break;
            @(negedge clk);
        end
        check("to_error_pulse", tx_error, 1'b1);
        check("to_busy", busy, 1'b0);
        check("to_no_done", done, 1'b0);
        @(negedge clk);
        check("to_error_one_cycle", tx_error, 1'b0);
        check("to_wr_count", wr_q.size(), 1);
        lat = (wr_cyc.size() > 0) ? err_cyc - wr_cyc[0] : -1;
        check("to_latency", lat, ACKT);
        check("to_done_count", done_cnt, 0);
        check("to_err_count", err_cnt, 1);
        ack_en = 1'b1;
        repeat (2) @(negedge clk);

        // Repeat: data change during pass 2 is ignored; change during pass 1 appears at the wrap.
        run_repeat(32'h88776655, 5, 64'h41424344_41424344);
        run_repeat(32'h48474645, 1, 64'h41424344_45464748);

        // Abort inside the gap after the first character, then an immediate fresh start.
        clear_log();
        msg_data  = 32'h44434241;
        repeat_en = 1'b0;
        pulse_start();
        wait_tx_busy(1'b1, 50);
        wait_tx_busy(1'b0, 50);
        repeat (3) @(negedge clk);
        check("ab_in_gap_idx", char_idx, 2'd1);
        check("ab_in_gap_busy", busy, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_busy", busy, 1'b0);
        check("ab_char_idx", char_idx, 2'd0);
        check("ab_tx_wr", Tx_WR, 1'b0);
        check("ab_no_done", done_cnt, 0);
        pulse_start();
        wait_idle(400);
        @(negedge clk);
        check("ab_wr_count", wr_q.size(), 5);
        for (int k = 1; k < 5; k++)
            if (k < wr_q.size())
                check($sformatf("ab_char%0d", k), wr_q[k], 8'h40 + 8'(k));
        check("ab_done_count", done_cnt, 1);

        // Reset mid-character, then start collides with abort in IDLE.
        clear_log();
        pulse_start();
        wait_tx_busy(1'b1, 50);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rs_tx_wr", Tx_WR, 1'b0);
        check("rs_tx_data", Tx_DATA, 8'h00);
        check("rs_busy", busy, 1'b0);
        check("rs_char_idx", char_idx, 2'd0);
        check("rs_done", done, 1'b0);
        check("rs_tx_error", tx_error, 1'b0);
        wr_q.delete();
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("rs_abort_wins_busy", busy, 1'b0);
        repeat (40) @(negedge clk);
        check("rs_no_wr", wr_q.size(), 0);
        check("rs_still_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
